// File: rtl/i2c_target_regs_if.sv
// ---------------------------------------------------------------------------
// i2c_target_regs_if
//
// Bundles the I2C pin-level signals shared between the bus environment and
// the register-file target.
//   scl     bus clock as seen at the target pin
//   sda_in  resolved SDA pin value (wired-AND of every open-drain driver)
//   sda_oe  target pull-down enable: 1 = pull SDA low, 0 = release
//
// Handshake note: I2C has no valid/ready pair. A bit is "valid" while SCL is
// high and may only change while SCL is low. The receiver of a byte
// acknowledges by pulling SDA low during the ninth SCL high phase.
//
// Modports:
//   master - drives scl and the resolved sda_in, observes sda_oe
//   slave  - the target: samples scl/sda_in, drives sda_oe
// ---------------------------------------------------------------------------
interface i2c_target_regs_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target with a NUM_REGS x 8 register file. It matches a 7-bit address,
// accepts pointer-then-data writes with auto-increment and serves sequential
// reads from the current pointer. SCL/SDA are oversampled on clk; SCL is never
// driven (no clock stretching).
//
// Ports:
//   clk        system clock (>= 8x SCL)
//   reset      asynchronous, active-low reset
//   bus        i2c_target_regs_if.slave: scl, sda_in in; sda_oe out
//   wr_stb     one-cycle pulse when a bus write updates the register file
//   wr_addr    register index of that write
//   wr_data    byte written
//   loc_addr   local read index
//   loc_data   regs[loc_addr], registered (1 clk latency)
//   busy       high from detected START to detected STOP
//   dbg_state  current FSM state encoding
//   dbg_ptr    current register pointer
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h70,
  parameter int         NUM_REGS   = 16,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_target_regs_if.slave       bus,
  output logic                   wr_stb,
  output logic [PW-1:0]          wr_addr,
  output logic [7:0]             wr_data,
  input  logic [PW-1:0]          loc_addr,
  output logic [7:0]             loc_data,
  output logic                   busy,
  output logic [3:0]             dbg_state,
  output logic [PW-1:0]          dbg_ptr
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8
  } state_t;

  state_t state, state_nxt;

  // -------------------------------------------------------------------------
  // Pin synchronizers plus one edge-detect register each. They reset to 1 to
  // match an idle bus so that reset release never looks like an edge.
  // -------------------------------------------------------------------------
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= bus.sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 & ~sda_s2 &  sda_d;
  assign stop_det  =  scl_s2 &  sda_s2 & ~sda_d;

  // -------------------------------------------------------------------------
  // Datapath registers and their next values
  // -------------------------------------------------------------------------
  logic [7:0]    regs [NUM_REGS];
  logic [7:0]    shift_q,   shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          ack_ph_q,  ack_ph_d;   // ACK slot: second half pending
  logic          rw_q,      rw_d;
  logic [PW-1:0] ptr_q,     ptr_d;
  logic          sda_oe_q,  sda_oe_d;
  logic          busy_q,    busy_d;
  logic          wr_en;

  logic [7:0]    shift_in;
  logic [7:0]    rd_byte;
  logic          byte_done;

  assign shift_in  = {shift_q[6:0], sda_s2};
  assign rd_byte   = regs[ptr_q];
  assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic. STOP and START win over bit handling in
  // every state, including IDLE after an address mismatch.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        ADDR:      if (byte_done)
                     state_nxt = (shift_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && ack_ph_q) state_nxt = rw_q ? RDATA : PTR;
        PTR:       if (byte_done) state_nxt = PTR_ACK;
        PTR_ACK:   if (scl_fall && ack_ph_q) state_nxt = WDATA;
        WDATA:     if (byte_done) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall && ack_ph_q) state_nxt = WDATA;
        RDATA:     if (scl_fall && (bit_cnt_q == 4'd8)) state_nxt = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda_s2)        state_nxt = IDLE;   // master NACK
          else if (scl_fall && ack_ph_q) state_nxt = RDATA;
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output / datapath decode. Bits are shifted in on SCL rise;
  // sda_oe only moves on SCL fall so the master never sees SDA change while
  // SCL is high.
  // -------------------------------------------------------------------------
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ack_ph_d  = ack_ph_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en     = 1'b0;

    if (stop_det) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
      ack_ph_d  = 1'b0;
    end else if (start_det) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_ph_d  = 1'b0;
              if (state == ADDR) begin
                rw_d = sda_s2;
              end else if (state == PTR) begin
                ptr_d = shift_in[PW-1:0];
              end else begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
              end
            end
          end
        end

        // First fall after the byte: pull SDA low for ACK. Second fall: end
        // of the ACK clock, either release or put the first read bit out.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if ((state == ADDR_ACK) && rw_q) begin
                shift_d   = rd_byte;
                sda_oe_d  = ~rd_byte[7];
                bit_cnt_d = 4'd1;
              end else begin
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        // bit_cnt counts bits already placed on SDA; shift_q[7] is on the bus.
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = 4'd0;
              ack_ph_d  = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) ack_ph_d = 1'b1;
          end else if (scl_fall && ack_ph_q) begin
            ack_ph_d  = 1'b0;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= 8'd0;
      bit_cnt_q <= 4'd0;
      ack_ph_q  <= 1'b0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ack_ph_q  <= ack_ph_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb    <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr_q;
        wr_data <= shift_in;
      end
    end
  end

  // Register file and local read port. The local read samples the array
  // before this cycle's write lands, so a same-cycle read returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
      loc_data <= 8'd0;
    end else begin
      if (wr_en) regs[ptr_q] <= shift_in;
      loc_data <= regs[loc_addr];
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign dbg_state  = state;
  assign dbg_ptr    = ptr_q;

endmodule
